spi_xfer_ctrl: RTL and testbench

// - Transaction sequencer for the SPI memory slave. Replaces the ad-hoc FSM between the input

---
 rtl/spi_xfer_ctrl.sv | 167 ++++++++++++++++
 tb/tb_spi_xfer_ctrl.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_xfer_ctrl.sv
// rtl/spi_xfer_ctrl.sv - SPI memory-slave transaction sequencer
//
// Purpose: sequences one SPI memory transaction. It counts conditioned SCLK
// rising edges, decodes the command byte (address MSB first, then R/W), and
// issues single-clock write-enable pulses to the address latch, shift
// register and data memory. It also gates the MISO tri-state buffer.
//
// Ports:
//   clk        FPGA clock, all state updates on posedge
//   rst_n      asynchronous active-low reset
//   sclk_rise  one-clk pulse per conditioned SCLK rising edge
//   sclk_fall  one-clk pulse per conditioned SCLK falling edge (debug only)
//   cs         conditioned chip select, active low
//   mosi       conditioned MOSI, sampled when sclk_rise=1
//   addr_we    address latch load pulse
//   sr_we      shift register parallel-load pulse
//   dm_we      data memory write pulse
//   miso_buf   MISO tri-state enable (level, read data phase only)
//   addr_inc   address latch increment pulse (burst build only)
//   state      3-bit state code for LEDs
//
// Build option: define SPI_BURST_EN to keep transferring data bytes at
// auto-incremented addresses until cs is released.

module spi_xfer_ctrl #(
  parameter int ADDR_W = 7,
  parameter int DATA_W = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       sclk_rise,
  input  logic       sclk_fall,
  input  logic       cs,
  input  logic       mosi,
  output logic       addr_we,
  output logic       sr_we,
  output logic       dm_we,
  output logic       miso_buf,
  output logic       addr_inc,
  output logic [2:0] state
);

  localparam int CMD_W = ADDR_W + 1;
  localparam int CNT_W = $clog2(DATA_W);
  localparam logic [CNT_W-1:0] CMD_LAST  = CNT_W'(CMD_W - 1);
  localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(DATA_W - 1);

  // Codes 0..7 are what the LEDs show. DONE and BURST live above that range
  // and are folded back onto visible codes at the state output.
  typedef enum logic [3:0] {
    S_IDLE     = 4'd0,
    S_GET_CMD  = 4'd1,
    S_LATCH    = 4'd2,
    S_RD_WAIT  = 4'd3,
    S_RD_LOAD  = 4'd4,
    S_RD_SHIFT = 4'd5,
    S_WR_SHIFT = 4'd6,
    S_WR_MEM   = 4'd7,
    S_DONE     = 4'd8,
    S_BURST    = 4'd9
  } fsm_t;

`ifdef SPI_BURST_EN
  localparam fsm_t AFTER_DATA = S_BURST;
`else
  localparam fsm_t AFTER_DATA = S_DONE;
`endif

  fsm_t             cur;
  fsm_t             nxt;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nx;
  logic             rw;
  logic             rw_nx;

  // Falling edges are only brought in for debug probing.
  logic unused_sclk_fall;
  assign unused_sclk_fall = sclk_fall;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cur <= S_IDLE;
      cnt <= '0;
      rw  <= 1'b0;
    end else begin
      cur <= nxt;
      cnt <= cnt_nx;
      rw  <= rw_nx;
    end
  end

  always_comb begin
    nxt      = cur;
    cnt_nx   = cnt;
    rw_nx    = rw;
    addr_we  = 1'b0;
    sr_we    = 1'b0;
    dm_we    = 1'b0;
    miso_buf = 1'b0;
    addr_inc = 1'b0;

    // Deselect wins over everything, including an SCLK edge in the same clk,
    // so a partial byte never reaches the memory.
    if (cs) begin
      nxt    = S_IDLE;
      cnt_nx = '0;
    end else begin
      unique case (cur)
        S_IDLE: begin
          nxt    = S_GET_CMD;
          cnt_nx = '0;
        end
        S_GET_CMD: begin
          if (sclk_rise) begin
            cnt_nx = cnt + CNT_W'(1);
            if (cnt == CMD_LAST) begin
              rw_nx = mosi;
              nxt   = S_LATCH;
            end
          end
        end
        S_LATCH:   nxt = rw ? S_RD_WAIT : S_WR_SHIFT;
        S_RD_WAIT: nxt = S_RD_LOAD;
        S_RD_LOAD: nxt = S_RD_SHIFT;
        S_RD_SHIFT: begin
          // The 8th rise is where the master samples the LSB.
          if (sclk_rise) begin
            cnt_nx = cnt + CNT_W'(1);
            if (cnt == DATA_LAST) nxt = AFTER_DATA;
          end
        end
        S_WR_SHIFT: begin
          if (sclk_rise) begin
            cnt_nx = cnt + CNT_W'(1);
            if (cnt == DATA_LAST) nxt = S_WR_MEM;
          end
        end
        S_WR_MEM: nxt = AFTER_DATA;
        S_DONE:   nxt = S_DONE;
`ifdef SPI_BURST_EN
        S_BURST:  nxt = rw ? S_RD_WAIT : S_WR_SHIFT;
`endif
        default:  nxt = S_IDLE;
      endcase
    end

    addr_we  = (cur == S_LATCH);
    sr_we    = (cur == S_RD_LOAD);
    dm_we    = (cur == S_WR_MEM);
    miso_buf = (cur == S_RD_SHIFT);
`ifdef SPI_BURST_EN
    addr_inc = (cur == S_BURST);
`else
    addr_inc = 1'b0;
`endif
  end

  // BURST shows as LATCH since the address latch is being updated then.
  always_comb begin
    case (cur)
      S_DONE:  state = 3'd0;
      S_BURST: state = 3'd2;
      default: state = cur[2:0];
    endcase
  end

endmodule

// File: tb/tb_spi_xfer_ctrl.sv
// tb/tb_spi_xfer_ctrl.sv - self-checking bench for spi_xfer_ctrl

module tb_spi_xfer_ctrl;

  localparam int NCYC = 4096;
  localparam int MAXT = 512;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       sclk_rise;
  logic       sclk_fall;
  logic       cs;
  logic       mosi;
  logic       addr_we;
  logic       sr_we;
  logic       dm_we;
  logic       miso_buf;
  logic       addr_inc;
  logic [2:0] state;

  spi_xfer_ctrl dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .sclk_rise (sclk_rise),
    .sclk_fall (sclk_fall),
    .cs        (cs),
    .mosi      (mosi),
    .addr_we   (addr_we),
    .sr_we     (sr_we),
    .dm_we     (dm_we),
    .miso_buf  (miso_buf),
    .addr_inc  (addr_inc),
    .state     (state)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic check(input string name, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s (cycle %0d): got 0x%0h, expected 0x%0h", name, cyc, act, exp);
  endtask

  // Expected per-cycle timeline: state code and {addr_we, sr_we, dm_we, miso_buf}.
  bit [2:0] exp_st [NCYC];
  bit [3:0] exp_pl [NCYC];
  int       base = 0;

  // Stimulus plan for one transaction, indexed by cycle offset from cs low.
  bit g_rise [MAXT];
  bit g_bit  [MAXT];

  function automatic void clr();
    for (int i = 0; i < MAXT; i++) begin
      g_rise[i] = 1'b0;
      g_bit[i]  = 1'b0;
    end
  endfunction

  // One byte MSB first, SCLK rising every 10 clk.
  function automatic void add_byte(input logic [7:0] b, input int start);
    for (int i = 0; i < 8; i++) begin
      g_rise[start + 10 * i] = 1'b1;
      g_bit[start + 10 * i]  = b[7 - i];
    end
  endfunction

  function automatic void put(input int c, input int zc, input bit [2:0] st, input bit [3:0] pl);
    if (c < zc && base + c < NCYC) begin
      exp_st[base + c] = st;
      exp_pl[base + c] = pl;
    end
  endfunction

  // Every cycle the outputs are compared with the timeline.
  always @(negedge clk) begin
    if (cyc < NCYC) begin
      check("state",    int'(state),    int'(exp_st[cyc]));
      check("addr_we",  int'(addr_we),  int'(exp_pl[cyc][3]));
      check("sr_we",    int'(sr_we),    int'(exp_pl[cyc][2]));
      check("dm_we",    int'(dm_we),    int'(exp_pl[cyc][1]));
      check("miso_buf", int'(miso_buf), int'(exp_pl[cyc][0]));
      check("addr_inc", int'(addr_inc), 0);
    end
  end

  // Bench-side memory datapath driven by the DUT's pulses.
  bit [7:0] mem [128];
  bit [7:0] mosi_sr = 8'h00;
  bit [6:0] dp_addr = 7'h00;
  bit [7:0] rd_sr   = 8'h00;
  bit [7:0] rd_byte = 8'h00;
  int n_aw = 0, n_sw = 0, n_dw = 0, n_rd = 0;
  int aw_cyc = 0, sw_cyc = 0, dw_cyc = 0;

  always @(negedge clk) begin
    if (sclk_rise) mosi_sr <= {mosi_sr[6:0], mosi};
    if (addr_we) begin dp_addr <= mosi_sr[7:1]; n_aw <= n_aw + 1; aw_cyc <= cyc; end
    if (dm_we)   begin mem[dp_addr] <= mosi_sr; n_dw <= n_dw + 1; dw_cyc <= cyc; end
    if (sr_we)   begin rd_sr <= mem[dp_addr];   n_sw <= n_sw + 1; sw_cyc <= cyc; end
    if (miso_buf && sclk_rise) begin
      rd_byte <= {rd_byte[6:0], rd_sr[7]};
      rd_sr   <= {rd_sr[6:0], 1'b0};
      n_rd    <= n_rd + 1;
    end
  end

  // Drives one transaction from the plan. cs goes high at offset cs_hi_off
  // (together with any rise planned there); rst_off >= 0 pulses rst_n
  // mid-cycle at that offset. The expected timeline is built first:
  // the first 8 rises after cs low are the command, the last being n; data
  // rises count from n+2 (write) or n+4 (read); cs high or reset cuts
  // everything to zero.
  task automatic run_xfer(input int cs_hi_off, input int rst_off);
    int  lim, zc, n, m, ds, cnt;
    bit  nf, mf, rw;
    @(posedge clk);
    #1;
    base = cyc;
    n = 0; m = 0; nf = 1'b0; mf = 1'b0; rw = 1'b0; cnt = 0;
    lim = (rst_off >= 0 && rst_off < cs_hi_off) ? rst_off : cs_hi_off;
    zc  = (rst_off >= 0 && rst_off <= cs_hi_off) ? rst_off : cs_hi_off + 1;
    for (int t = 1; t < lim && !nf; t++) begin
      if (g_rise[t]) begin
        cnt++;
        if (cnt == 8) begin nf = 1'b1; n = t; rw = g_bit[t]; end
      end
    end
    for (int c = 1; c <= (nf ? n : zc - 1); c++) put(c, zc, 3'd1, 4'b0000);
    if (nf) begin
      put(n + 1, zc, 3'd2, 4'b1000);
      if (rw) begin
        put(n + 2, zc, 3'd3, 4'b0000);
        put(n + 3, zc, 3'd4, 4'b0100);
      end
      ds  = rw ? n + 4 : n + 2;
      cnt = 0;
      for (int t = ds; t < lim && !mf; t++) begin
        if (g_rise[t]) begin
          cnt++;
          if (cnt == 8) begin mf = 1'b1; m = t; end
        end
      end
      for (int c = ds; c <= (mf ? m : zc - 1); c++)
        put(c, zc, rw ? 3'd5 : 3'd6, rw ? 4'b0001 : 4'b0000);
      if (mf && !rw) put(m + 1, zc, 3'd7, 4'b0010);
    end

    for (int t = 0; t <= cs_hi_off + 3; t++) begin
      if (t > 0) begin
        @(posedge clk);
        #1;
      end
      cs        = (t >= cs_hi_off);
      sclk_rise = g_rise[t];
      if (g_rise[t]) mosi = g_bit[t];
      sclk_fall = (t >= 5) ? g_rise[(t >= 5) ? t - 5 : 0] : 1'b0;
      if (t == rst_off) begin
        check("miso_buf before reset", int'(miso_buf), 1);
        #1 rst_n = 1'b0;
        #1 check("outputs in async reset",
                 int'({state, addr_we, sr_we, dm_we, miso_buf, addr_inc}), 0);
      end
      if (rst_off >= 0 && t == rst_off + 1) rst_n = 1'b1;
      if (rst_off >= 0 && t == rst_off + 2) check("state after reset release", int'(state), 0);
    end
    sclk_rise = 1'b0;
    sclk_fall = 1'b0;
  endtask

  int p_aw, p_sw, p_dw, p_rd;

  function automatic void snap();
    p_aw = n_aw; p_sw = n_sw; p_dw = n_dw; p_rd = n_rd;
  endfunction

  initial begin
    rst_n = 1'b0; cs = 1'b1; sclk_rise = 1'b0; sclk_fall = 1'b0; mosi = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset outputs", int'({state, addr_we, sr_we, dm_we, miso_buf, addr_inc}), 0);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);

    // Write 0xC3 to 0x2A.
    clr(); add_byte(8'h54, 5); add_byte(8'hC3, 85);
    snap(); run_xfer(165, -1);
    check("wr addr_we pulses", n_aw - p_aw, 1);
    check("wr dm_we pulses", n_dw - p_dw, 1);
    check("wr sr_we pulses", n_sw - p_sw, 0);
    check("wr addr_we latency", aw_cyc - base, 76);
    check("wr dm_we latency", dw_cyc - base, 156);
    check("mem[0x2A]", int'(mem[7'h2A]), 8'hC3);

    // Read 0x2A, with a stray rise during the read-wait gap.
    clr(); add_byte(8'h55, 5); g_rise[77] = 1'b1; add_byte(8'h00, 85);
    snap(); run_xfer(165, -1);
    check("rd addr_we latency", aw_cyc - base, 76);
    check("rd sr_we latency", sw_cyc - base, 78);
    check("rd sr_we pulses", n_sw - p_sw, 1);
    check("rd miso rises", n_rd - p_rd, 8);
    check("rd data", int'(rd_byte), 8'hC3);

    // Write 0x5A to 0x10, then abort a second write after 5 data bits.
    clr(); add_byte(8'h20, 5); add_byte(8'h5A, 85);
    run_xfer(165, -1);
    check("mem[0x10] written", int'(mem[7'h10]), 8'h5A);
    clr(); add_byte(8'h20, 5);
    for (int i = 0; i < 5; i++) begin g_rise[85 + 10 * i] = 1'b1; g_bit[85 + 10 * i] = 1'b1; end
    snap(); run_xfer(130, -1);
    check("abort addr_we pulses", n_aw - p_aw, 1);
    check("abort dm_we pulses", n_dw - p_dw, 0);
    check("mem[0x10] after abort", int'(mem[7'h10]), 8'h5A);

    // cs release in the same clk as the 8th command rise.
    clr(); add_byte(8'h55, 5);
    snap(); run_xfer(75, -1);
    check("simul addr_we pulses", n_aw - p_aw, 0);

    // Reset during the read data phase, after 3 bits.
    clr(); add_byte(8'h55, 5); add_byte(8'h00, 85);
    snap(); run_xfer(110, 110);
    check("reset-read miso rises", n_rd - p_rd, 3);

    // A clean read afterwards.
    clr(); add_byte(8'h55, 5); add_byte(8'h00, 85);
    snap(); run_xfer(165, -1);
    check("post-reset rd data", int'(rd_byte), 8'hC3);
    check("post-reset miso rises", n_rd - p_rd, 8);

    repeat (2) @(posedge clk);
    #1;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
